// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the two-entry skid stage: occupancy states
// and the default field widths of the packed payload.
package pipe_skid_stage_pkg;

    localparam int PCP4_W    = 32;
    localparam int MEM_W     = 32;
    localparam int BUSB_W    = 32;
    localparam int WBADDR_W  = 5;
    localparam int MEMTOREG_W = 2;
    localparam int REGWR_W   = 1;

    localparam int PAYLOAD_W = PCP4_W + MEM_W + BUSB_W
                             + WBADDR_W + MEMTOREG_W + REGWR_W;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage with registered in_ready, flush
// and a saturating downstream-stall counter.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int W     = PAYLOAD_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    state_e         state_q;
    state_e         state_d;
    logic [W-1:0]   main_q;
    logic [W-1:0]   main_d;
    logic [W-1:0]   skid_q;
    logic [W-1:0]   skid_d;
    logic           in_ready_q;
    logic           accept;
    logic           issue;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign issue     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (issue) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // in_ready looks ahead at the next state so it can be a plain flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (stall_clr),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pipe_skid_stage;

    localparam int W     = 104;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_clr;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_skid_stage #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2 with a visible head.
    logic [W-1:0] mq[$];
    logic [W-1:0] shown = '0;
    int           m_cnt = 0;

    always @(posedge clk or posedge reset) begin
        bit m_ov, m_ir, m_acc, m_iss;
        if (reset) begin
            mq.delete();
            shown = '0;
            m_cnt = 0;
        end else begin
            m_ov  = (mq.size() > 0);
            m_ir  = (mq.size() < 2);
            m_acc = in_valid && m_ir;
            m_iss = m_ov && out_ready;
            if (stall_clr) m_cnt = 0;
            else if (m_ov && !out_ready && m_cnt < CMAX) m_cnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_iss) void'(mq.pop_front());
                if (m_acc) mq.push_back(in_data);
            end
            if (mq.size() > 0) shown = mq[0];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_valid", 128'(out_valid), 128'(mq.size() > 0));
            chk("m_ready", 128'(in_ready), 128'(mq.size() < 2));
            chk("m_occ", 128'(occupancy), 128'(mq.size()));
            chk("m_data", 128'(out_data), 128'(shown));
            chk("m_stall", 128'(stall_cnt), 128'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        stall_clr = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic fill_ab();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        tick();
        in_data = W'('hB);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] r;
        logic         ir0;

        do_reset();
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_occ", 128'(occupancy), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));
        chk("rst_stall", 128'(stall_cnt), 128'(0));

        // Streaming: one-cycle latency, occupancy stays at 1.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_data = W'(k);
            tick();
            chk("str_data", 128'(out_data), 128'(k));
            chk("str_occ", 128'(occupancy), 128'(1));
            chk("str_ready", 128'(in_ready), 128'(1));
            chk("str_valid", 128'(out_valid), 128'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("str_drain", 128'(out_valid), 128'(0));

        // Backpressure: A, B fill the stage, C waits upstream.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        tick();
        chk("bp_occ1", 128'(occupancy), 128'(1));
        chk("bp_rdy1", 128'(in_ready), 128'(1));
        in_data = W'('hB);
        tick();
        chk("bp_occ2", 128'(occupancy), 128'(2));
        chk("bp_rdy2", 128'(in_ready), 128'(0));
        in_data = W'('hC);
        tick();
        chk("bp_hold", 128'(out_data), 128'('hA));
        chk("bp_occ3", 128'(occupancy), 128'(2));
        out_ready = 1'b1;
        tick();
        chk("bp_B", 128'(out_data), 128'('hB));
        tick();
        chk("bp_C", 128'(out_data), 128'('hC));
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 128'(out_valid), 128'(0));

        // Flush while full with a concurrent offer of D.
        do_reset();
        fill_ab();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = W'('hD);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 128'(out_valid), 128'(0));
        chk("fl_occ", 128'(occupancy), 128'(0));
        chk("fl_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_noD", 128'(out_valid), 128'(0));

        // Stall counter saturation and clear.
        do_reset();
        in_valid = 1'b1;
        in_data  = W'('h77);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_15", 128'(stall_cnt), 128'(15));
        tick();
        chk("sat_hold", 128'(stall_cnt), 128'(15));
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("sat_clr", 128'(stall_cnt), 128'(0));

        // Asynchronous reset mid-cycle while full.
        do_reset();
        fill_ab();
        chk("ar_full", 128'(occupancy), 128'(2));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_valid", 128'(out_valid), 128'(0));
        chk("ar_data", 128'(out_data), 128'(0));
        chk("ar_occ", 128'(occupancy), 128'(0));
        chk("ar_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            if ((i % 16) == 0) begin
                ir0       = in_ready;
                out_ready = ~out_ready;
                #1;
                chk("ir_comb", 128'(in_ready), 128'(ir0));
            end
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_data   = r[W-1:0];
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 63) == 0);
            stall_clr = ($urandom_range(0, 199) == 0);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("end_drain", 128'(out_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
